// File: rtl/bubble_sorter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bubble_sorter_pkg                                        |
// | Brief    : Shared state encoding and pointer-width helper.          |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package bubble_sorter_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } sort_state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bubble_sorter_cmp_swap.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : cmp_swap_unit                                            |
// | Brief    : Unsigned compare-and-swap; lo_o/hi_o are the pair in     |
// |            output order (lo_o lands at the lower index).            |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module cmp_swap_unit #(
    parameter int N       = 8,
    parameter bit DESCEND = 1'b0
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         swap_o,
    output logic [N-1:0] lo_o,
    output logic [N-1:0] hi_o
);

    // Strict compare keeps equal words in place, which makes the sort stable.
    assign swap_o = DESCEND ? (a_i < b_i) : (a_i > b_i);
    assign lo_o   = swap_o ? b_i : a_i;
    assign hi_o   = swap_o ? a_i : b_i;

endmodule
`default_nettype wire

// File: rtl/bubble_sorter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bubble_sorter                                            |
// | Brief    : Collects DEPTH words, bubble-sorts them in place with a  |
// |            single shared compare-and-swap, then streams them out.   |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module bubble_sorter
    import bubble_sorter_pkg::*;
#(
    parameter int N       = 8,
    parameter int DEPTH   = 4,
    parameter bit DESCEND = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] c_last_idx = PW'(DEPTH - 1);
    localparam logic [PW-1:0] c_last_cmp = PW'(DEPTH - 2);

    sort_state_t   state_q, state_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] p_q, p_d;
    logic [PW-1:0] i_q, i_d;
    logic          swapped_q, swapped_d;
    logic [N-1:0]  mem_q [DEPTH];

    logic [PW-1:0] w_i_nxt;
    logic          w_swap;
    logic [N-1:0]  w_lo;
    logic [N-1:0]  w_hi;

    assign w_i_nxt = i_q + PW'(1);

    cmp_swap_unit #(
        .N       (N),
        .DESCEND (DESCEND)
    ) u_cmp (
        .a_i    (mem_q[i_q]),
        .b_i    (mem_q[w_i_nxt]),
        .swap_o (w_swap),
        .lo_o   (w_lo),
        .hi_o   (w_hi)
    );

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        p_d       = p_q;
        i_d       = i_q;
        swapped_d = swapped_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    if (wr_q == c_last_idx) begin
                        state_d   = SORT;
                        p_d       = '0;
                        i_d       = '0;
                        swapped_d = 1'b0;
                    end else begin
                        wr_d = wr_q + PW'(1);
                    end
                end
            end
            SORT: begin
                if (w_swap) begin
                    swapped_d = 1'b1;
                end
                // A swap on the closing compare still counts toward this pass.
                if (i_q == c_last_cmp - p_q) begin
                    if (!(swapped_q || w_swap) || (p_q == c_last_cmp)) begin
                        state_d = DRAIN;
                    end else begin
                        p_d       = p_q + PW'(1);
                        i_d       = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    i_d = w_i_nxt;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_q == c_last_idx) begin
                        rd_d    = '0;
                        wr_d    = '0;
                        state_d = LOAD;
                    end else begin
                        rd_d = rd_q + PW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD;
            wr_q      <= '0;
            rd_q      <= '0;
            p_q       <= '0;
            i_q       <= '0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            p_q       <= p_d;
            i_q       <= i_d;
            swapped_q <= swapped_d;
        end
    end

    // Storage carries no reset; stale contents are masked by the output gating.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if ((state_q == LOAD) && in_valid) begin
                mem_q[wr_q] <= in_data;
            end else if ((state_q == SORT) && w_swap) begin
                mem_q[i_q]     <= w_lo;
                mem_q[w_i_nxt] <= w_hi;
            end
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != LOAD);
    assign out_data  = out_valid ? mem_q[rd_q] : '0;
    assign out_last  = out_valid && (rd_q == c_last_idx);

endmodule
`default_nettype wire

// File: tb/tb_bubble_sorter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_bubble_sorter                                         |
// | Brief    : Scoreboard bench driving an ascending and a descending   |
// |            sorter with the same input stream.                       |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_bubble_sorter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [7:0] a_out_data;
    logic       d_in_ready, d_out_valid, d_out_last, d_busy;
    logic [7:0] d_out_data;

    int checks = 0;
    int fails  = 0;
    int hold_cnt = 0;

    logic [8:0] expq [2][$];
    int         lenq [2][$];
    bit         prev_v [2];
    bit         stall [2];
    logic [8:0] held [2];
    int         sort_cnt [2];

    always #5 clk = ~clk;

    bubble_sorter #(.N(8), .DEPTH(4), .DESCEND(1'b0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy)
    );

    bubble_sorter #(.N(8), .DEPTH(4), .DESCEND(1'b1)) dut_d (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_data(in_data), .out_valid(d_out_valid), .out_ready(out_ready),
        .out_data(d_out_data), .out_last(d_out_last), .busy(d_busy)
    );

    task automatic chk(input string name, input int u, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, u, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int u);
        checks++;
        fails++;
        $display("FAIL %s dut%0d at %0t", name, u, $time);
    endtask

    function automatic bit goes_before(input logic [7:0] x, input logic [7:0] y, input int dir);
        return (dir != 0) ? (x > y) : (x < y);
    endfunction

    // Reference: stable sort by original position, and SORT length from the
    // largest count of out-of-order predecessors (bubble pass bound).
    task automatic push_expected(input logic [7:0] w[4]);
        for (int u = 0; u < 2; u++) begin
            int ord[4];
            int k, cnt, passes, cyc, t;
            for (int i = 0; i < 4; i++) ord[i] = i;
            for (int i = 1; i < 4; i++) begin
                for (int j = i; j > 0; j--) begin
                    if (goes_before(w[ord[j]], w[ord[j-1]], u)) begin
                        t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
                    end else begin
                        break;
                    end
                end
            end
            for (int i = 0; i < 4; i++) expq[u].push_back({(i == 3), w[ord[i]]});
            k = 0;
            for (int j = 0; j < 4; j++) begin
                cnt = 0;
                for (int i = 0; i < j; i++) if (goes_before(w[j], w[i], u)) cnt++;
                if (cnt > k) k = cnt;
            end
            passes = (k + 1 < 3) ? k + 1 : 3;
            cyc = 0;
            for (int p = 0; p < passes; p++) cyc += 3 - p;
            lenq[u].push_back(cyc);
        end
    endtask

    task automatic mon_step(input int u, input logic v, input logic r, input logic [7:0] d,
                            input logic l, input logic b);
        logic [8:0] e;
        if (v) begin
            if (!prev_v[u]) begin
                if (lenq[u].size() == 0) fail_now("unexpected_out_valid", u);
                else chk("sort_cycles", u, sort_cnt[u], lenq[u].pop_front());
                sort_cnt[u] = 0;
            end
            if (stall[u]) chk("stall_hold", u, {l, d}, held[u]);
            if (r) begin
                if (expq[u].size() == 0) begin
                    fail_now("extra_word", u);
                end else begin
                    e = expq[u].pop_front();
                    chk("out_data", u, d, e[7:0]);
                    chk("out_last", u, l, e[8]);
                end
            end
            stall[u] = !r;
            held[u]  = {l, d};
        end else begin
            chk("idle_data_zero", u, d, 0);
            stall[u] = 1'b0;
            if (b) sort_cnt[u]++;
        end
        prev_v[u] = v;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int u = 0; u < 2; u++) begin
                prev_v[u] = 1'b0; stall[u] = 1'b0; sort_cnt[u] = 0;
            end
        end else begin
            mon_step(0, a_out_valid, out_ready, a_out_data, a_out_last, a_busy);
            mon_step(1, d_out_valid, out_ready, d_out_data, d_out_last, d_busy);
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
        end else begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic load_batch(input logic [7:0] w[4], input bit track, input bit rand_valid);
        int idx = 0;
        int guard = 0;
        bit v;
        if (track) push_expected(w);
        while (idx < 4 && guard < 400) begin
            @(negedge clk);
            guard++;
            v = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!(a_in_ready && d_in_ready)) v = 1'b0;
            in_valid = v;
            in_data  = w[idx];
            if (v) idx++;
        end
        if (idx < 4) fail_now("load_timeout", 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(a_in_ready && d_in_ready && expq[0].size() == 0 && expq[1].size() == 0)
                   && guard < 500);
        if (guard >= 500) fail_now("idle_timeout", 0);
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk("rst_in_ready", 0, a_in_ready, 1);
        chk("rst_out_valid", 0, a_out_valid, 0);
        chk("rst_busy", 0, a_busy, 0);
        chk("rst_out_data", 0, a_out_data, 0);
        chk("rst_out_last", 0, a_out_last, 0);
        chk("rst_in_ready", 1, d_in_ready, 1);
        chk("rst_out_valid", 1, d_out_valid, 0);
        chk("rst_busy", 1, d_busy, 0);
    endtask

    initial begin
        logic [7:0] w[4];
        int guard;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state();

        load_batch('{8'd5, 8'd3, 8'd9, 8'd1}, 1'b1, 1'b0);
        wait_idle();
        load_batch('{8'd1, 8'd2, 8'd3, 8'd4}, 1'b1, 1'b0);
        wait_idle();
        load_batch('{8'd7, 8'd7, 8'd0, 8'd255}, 1'b1, 1'b0);
        wait_idle();

        // Backpressure in DRAIN with a ragged producer.
        for (int i = 0; i < 4; i++) w[i] = 8'($urandom_range(0, 255));
        load_batch(w, 1'b1, 1'b1);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!a_out_valid && guard < 100);
        if (guard >= 100) fail_now("drain_timeout", 0);
        hold_cnt = 5;
        wait_idle();

        // Reset lands on the third SORT cycle; nothing may come out.
        load_batch('{8'd4, 8'd8, 8'd6, 8'd2}, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state();
        repeat (10) @(negedge clk);

        load_batch('{8'd8, 8'd6, 8'd4, 8'd2}, 1'b1, 1'b0);
        wait_idle();

        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 4; i++)
                w[i] = (b % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3) * 60);
            load_batch(w, 1'b1, (b % 3) == 0);
            wait_idle();
        end

        chk("exp_left_asc", 0, expq[0].size(), 0);
        chk("exp_left_desc", 1, expq[1].size(), 0);
        chk("len_left_asc", 0, lenq[0].size(), 0);
        chk("len_left_desc", 1, lenq[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bubble_sorter.md
# bubble_sorter

Sequential sort engine that sequences one shared N-bit magnitude compare-and-swap unit over a small register file. It collects DEPTH unsigned words through a valid/ready input stream and sorts them in place with bubble-sort passes, one compare per cycle. It then streams the sorted words out with a last flag. It sits between a producer and a consumer that need small ordered batches, such as min/max selection or median pick.

## Interface
- N, 8, data width in bits (≥1)
- DEPTH, 4, words per batch (≥2)
- DESCEND, 0, 0 = ascending (smallest first), 1 = descending
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  producer offers in_data
- in_ready  output  1  block accepts a word this cycle
- in_data  input  N  unsigned word
- out_valid  output  1  out_data holds a sorted word
- out_ready  input  1  consumer accepts out_data
- out_data  output  N  current sorted word
- out_last  output  1  high with the final word of a batch
- busy  output  1  high in SORT and DRAIN

## Operation
- The FSM has three states: LOAD, SORT and DRAIN.
- **LOAD**
  - in_ready=1.
  - On in_valid&&in_ready: mem[wr]←in_data, then wr++.
  - When the accepted word is index DEPTH-1: go to SORT with pass p=0, index i=0, swapped=0.
- **SORT**
  - One compare per cycle on a=mem[i], b=mem[i+1].
  - Swap when a>b (ascending) or a<b (descending). Equal values are never swapped, so the sort is stable.
  - A swap writes both entries on the same edge and sets swapped=1.
  - When i=DEPTH-2-p, the pass ends:
    - if swapped=0 or p=DEPTH-2: go to DRAIN;
    - else p++, i=0, swapped=0.
  - Otherwise i++.
- **DRAIN**
  - out_valid=1, out_data=mem[rd], out_last=(rd==DEPTH-1).
  - On out_valid&&out_ready: rd++.
  - On the last handshake: rd=0, wr=0, go to LOAD.
- Comparisons are unsigned, full N bits, with no truncation.
- Pointers and counters are $clog2(DEPTH) bits wide, minimum 1. They never wrap inside a state because terminal compares are explicit.
- Reset (at any time, including mid-SORT or mid-DRAIN):
  - next state LOAD;
  - wr, rd, p, i and swapped cleared;
  - mem contents become don't-care and must not leak: out_valid=0.
  - The partial batch is discarded.
- Reset values after the reset edge: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
  - out_data is gated to 0 whenever out_valid=0.
- While reset is high, in_valid and out_ready are ignored.

## Timing
- All outputs are decoded from registered state and pointers. There is no combinational path from in_valid or out_ready to any output.
- LOAD takes DEPTH accepted handshakes; producer stalls are allowed.
- SORT starts the cycle after the last load handshake.
- SORT length:
  - worst case DEPTH·(DEPTH-1)/2 cycles;
  - minimum DEPTH-1 cycles, when the input is already ordered (early exit after pass 0).
- out_valid rises the cycle after the final SORT compare.
- DRAIN takes DEPTH handshakes. out_data holds stable while out_valid&&!out_ready.
- in_ready rises the cycle after the last output handshake. There is no overlap between batches.

## Structure
- **Package bubble_sorter_pkg**
  - typedef enum logic [1:0] {LOAD, SORT, DRAIN} sort_state_t.
  - Function ptr_w(depth) returns max(1, $clog2(depth)).
- **Sub-module cmp_swap_unit #(N, DESCEND)**
  - Inputs: a, b.
  - Outputs: swap, lo_out, hi_out (ordered pair).
  - Purely combinational; one instance, shared by every compare step.
- **Top level:** FSM, mem array, wr/rd/p/i counters and the swapped flag.

## Test plan
- **Reset:** reset high 2 cycles, then release → in_ready=1, out_valid=0, busy=0, out_data=0.
- **Scramble (DEPTH=4, N=8, ascending):** load 5,3,9,1 → SORT lasts exactly 6 cycles; output 1,3,5,9 with out_last only on 9.
- **Early exit:** load 1,2,3,4 → SORT lasts 3 cycles; output 1,2,3,4.
- **Descending and ties:** DESCEND=1, load 7,7,0,255 → output 255,7,7,0. Tag the equal words via bench ordering to prove they were not swapped (stability).
- **Backpressure:** hold out_ready=0 for 5 cycles during DRAIN → out_data and out_last stable, no word lost or duplicated. A random in_valid pattern during LOAD → all 4 words captured.
- **Mid-operation reset:** assert reset on the 3rd SORT cycle → out_valid never rises. After release, a fresh batch 8,6,4,2 outputs 2,4,6,8.
